// File: rtl/conv_ctrl.sv
// conv_ctrl: 3x3 convolution sequencer over a single request/response memory port.
// Optional build macro CONV_CTRL_RELU_EN clamps negative results to zero before writing.
module conv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] ifm_offset_i,
    input  logic [31:0] wt_offset_i,
    input  logic [31:0] ofm_offset_i,
    input  logic [31:0] fm_dim_i,
    output logic        idle_o,
    output logic        done_o,
    output logic        mem_req_valid_o,
    output logic        mem_req_we_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    output logic [31:0] mem_req_wdata_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_rdata_i
);
    typedef enum logic [2:0] {IDLE, LOAD_WT, WAIT_WT, FETCH, WAIT_PX, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] ifm_q, ifm_d, wt_q, wt_d, ofm_q, ofm_d;
    logic [7:0]  n_q, n_d, r_q, r_d, c_q, c_d;
    logic [3:0]  k_q, k_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] w_q [9];
    logic [31:0] w_d [9];
    logic        valid_q, valid_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] acc_sum;
    logic        c_last, last_px;
    logic [7:0]  nr, nc;
    logic        unused_dim;

    assign unused_dim = ^fm_dim_i[31:8];

    // Address of tap k (row-major over the 3x3 window) for output pixel (r,c).
    function automatic logic [31:0] px_addr(input logic [31:0] base, input logic [7:0] n,
                                            input logic [7:0] r, input logic [7:0] c,
                                            input logic [3:0] k);
        logic [31:0] kr, kc;
        kr = (k >= 4'd6) ? 32'd2 : (k >= 4'd3) ? 32'd1 : 32'd0;
        kc = 32'(k) - 32'd3 * kr;
        return base + (((32'(r) + kr) * 32'(n) + 32'(c) + kc) << 2);
    endfunction

    function automatic logic [31:0] out_val(input logic [31:0] acc);
`ifdef CONV_CTRL_RELU_EN
        return acc[31] ? 32'd0 : acc;
`else
        return acc;
`endif
    endfunction

    assign acc_sum = acc_q + mem_resp_rdata_i * w_q[k_q];
    assign c_last  = c_q == n_q - 8'd3;
    assign last_px = c_last && (r_q == n_q - 8'd3);
    assign nc      = c_last ? 8'd0 : c_q + 8'd1;
    assign nr      = c_last ? r_q + 8'd1 : r_q;

    assign idle_o          = (state_q == IDLE) || (state_q == DONE);
    assign done_o          = state_q == DONE;
    assign mem_req_valid_o = valid_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_wdata_o = wdata_q;

    // Next-state logic; each request is set up on the transition into its issuing state and held until accepted.
    always_comb begin
        state_d = state_q;
        ifm_d   = ifm_q;
        wt_d    = wt_q;
        ofm_d   = ofm_q;
        n_d     = n_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        acc_d   = acc_q;
        w_d     = w_q;
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE: if (start_i) begin
                ifm_d = ifm_offset_i;
                wt_d  = wt_offset_i;
                ofm_d = ofm_offset_i;
                n_d   = fm_dim_i[7:0];
                k_d   = 4'd0;
                if (fm_dim_i[7:0] < 8'd3) begin
                    // From DONE a degenerate job passes through LOAD_WT with no request so done_o drops for a cycle.
                    state_d = (state_q == IDLE) ? DONE : LOAD_WT;
                end else begin
                    state_d = LOAD_WT;
                    valid_d = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = wt_offset_i;
                end
            end
            LOAD_WT: begin
                if (!valid_q) state_d = DONE;
                else if (mem_req_ready_i) begin
                    valid_d = 1'b0;
                    state_d = WAIT_WT;
                end
            end
            WAIT_WT: if (mem_resp_valid_i) begin
                w_d[k_q] = mem_resp_rdata_i;
                valid_d  = 1'b1;
                if (k_q == 4'd8) begin
                    k_d     = 4'd0;
                    r_d     = 8'd0;
                    c_d     = 8'd0;
                    acc_d   = 32'd0;
                    state_d = FETCH;
                    addr_d  = px_addr(ifm_q, n_q, 8'd0, 8'd0, 4'd0);
                end else begin
                    k_d     = k_q + 4'd1;
                    state_d = LOAD_WT;
                    addr_d  = wt_q + (32'(k_q + 4'd1) << 2);
                end
            end
            FETCH: if (mem_req_ready_i) begin
                valid_d = 1'b0;
                state_d = WAIT_PX;
            end
            WAIT_PX: if (mem_resp_valid_i) begin
                acc_d   = acc_sum;
                valid_d = 1'b1;
                if (k_q == 4'd8) begin
                    k_d     = 4'd0;
                    we_d    = 1'b1;
                    addr_d  = ofm_q + ((32'(r_q) * (32'(n_q) - 32'd2) + 32'(c_q)) << 2);
                    wdata_d = out_val(acc_sum);
                    state_d = WRITE;
                end else begin
                    k_d     = k_q + 4'd1;
                    addr_d  = px_addr(ifm_q, n_q, r_q, c_q, k_q + 4'd1);
                    state_d = FETCH;
                end
            end
            WRITE: if (mem_req_ready_i) begin
                valid_d = 1'b0;
                we_d    = 1'b0;
                if (last_px) state_d = DONE;
                else begin
                    r_d     = nr;
                    c_d     = nc;
                    acc_d   = 32'd0;
                    valid_d = 1'b1;
                    addr_d  = px_addr(ifm_q, n_q, nr, nc, 4'd0);
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any job and clears all pending requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ifm_q   <= '0;
            wt_q    <= '0;
            ofm_q   <= '0;
            n_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            w_q     <= '{default: '0};
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ifm_q   <= ifm_d;
            wt_q    <= wt_d;
            ofm_q   <= ofm_d;
            n_q     <= n_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: directed bench for conv_ctrl with a one-cycle-latency memory model and optional ready stalls.
module tb_conv_ctrl;
    localparam logic [31:0] WT  = 32'h100;
    localparam logic [31:0] IFM = 32'h200;
    localparam logic [31:0] OFM = 32'h400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] ifm_offset_i = '0, wt_offset_i = '0, ofm_offset_i = '0, fm_dim_i = '0;
    logic        idle_o, done_o;
    logic        mem_req_valid_o, mem_req_we_o, mem_req_ready_i;
    logic [31:0] mem_req_addr_o, mem_req_wdata_o;
    logic        mem_resp_valid_i = 1'b0;
    logic [31:0] mem_resp_rdata_i = '0;

    logic [31:0] wt_m [9];
    logic [31:0] ifm_m [16];
    logic [31:0] wa [$];
    logic [31:0] wd [$];
    int          rd_cnt = 0, vcnt = 0, wait_cnt = 0, stall = 0;
    int          stab_bad = 0, stab_n = 0;
    logic        hold_v = 1'b0, hold_we = 1'b0;
    logic [31:0] hold_addr = '0, hold_wdata = '0;
    int          checks = 0, failures = 0;

    conv_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .ifm_offset_i(ifm_offset_i), .wt_offset_i(wt_offset_i), .ofm_offset_i(ofm_offset_i),
        .fm_dim_i(fm_dim_i), .idle_o(idle_o), .done_o(done_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_we_o(mem_req_we_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_rdata_i(mem_resp_rdata_i)
    );

    always #5 clk = ~clk;

    assign mem_req_ready_i = wait_cnt >= stall;

    function automatic logic [31:0] rd(input logic [31:0] a);
        int idx;
        if (a >= WT && a < WT + 32'd36) begin
            idx = int'((a - WT) >> 2);
            return wt_m[idx];
        end
        if (a >= IFM && a < IFM + 32'd64) begin
            idx = int'((a - IFM) >> 2);
            return ifm_m[idx];
        end
        return 32'hDEADBEEF;
    endfunction

    // Memory model: accepts requests, answers reads one cycle later, logs writes and hold stability.
    always @(posedge clk) begin
        mem_resp_valid_i <= mem_req_valid_o && mem_req_ready_i && !mem_req_we_o;
        mem_resp_rdata_i <= rd(mem_req_addr_o);
        wait_cnt <= (mem_req_valid_o && !mem_req_ready_i) ? wait_cnt + 1 : 0;
        if (mem_req_valid_o) vcnt <= vcnt + 1;
        if (mem_req_valid_o && mem_req_ready_i) begin
            if (mem_req_we_o) begin
                wa.push_back(mem_req_addr_o);
                wd.push_back(mem_req_wdata_o);
            end else rd_cnt <= rd_cnt + 1;
        end
        if (hold_v && mem_req_valid_o) begin
            stab_n <= stab_n + 1;
            if (mem_req_addr_o !== hold_addr || mem_req_we_o !== hold_we || mem_req_wdata_o !== hold_wdata)
                stab_bad <= stab_bad + 1;
        end
        hold_v     <= mem_req_valid_o && !mem_req_ready_i;
        hold_addr  <= mem_req_addr_o;
        hold_we    <= mem_req_we_o;
        hold_wdata <= mem_req_wdata_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] n);
        @(negedge clk);
        ifm_offset_i = IFM;
        wt_offset_i  = WT;
        ofm_offset_i = OFM;
        fm_dim_i     = {24'hA5C3E1, n};
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
        ifm_offset_i = 32'hBAD0;
        wt_offset_i  = 32'hBAD4;
        ofm_offset_i = 32'hBAD8;
        fm_dim_i     = 32'd7;
    endtask

    task automatic run_job(input string tag, input logic [7:0] n);
        pulse_start(n);
        for (int i = 0; i < 3000; i++) begin
            if (done_o) break;
            @(negedge clk);
        end
        check({tag, "_done"}, {31'd0, done_o}, 32'd1);
        check({tag, "_idle"}, {31'd0, idle_o}, 32'd1);
    endtask

    initial begin
        int w0, r0, v0;
        logic found;
        #2;
        check("rst_idle", {31'd0, idle_o}, 32'd1);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_valid", {31'd0, mem_req_valid_o}, 32'd0);
        check("rst_we", {31'd0, mem_req_we_o}, 32'd0);
        check("rst_addr", mem_req_addr_o, 32'd0);
        check("rst_wdata", mem_req_wdata_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // N=2: immediate DONE, no requests; restart from DONE drops done_o for one cycle.
        v0 = vcnt;
        pulse_start(8'd2);
        check("n2_done", {31'd0, done_o}, 32'd1);
        @(negedge clk);
        start_i  = 1'b1;
        fm_dim_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0;
        check("n2_restart_low", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        check("n2_restart_high", {31'd0, done_o}, 32'd1);
        check("n2_no_valid", vcnt - v0, 32'd0);

        // N=3, all-ones weights, ifm 1..9.
        for (int i = 0; i < 9; i++) begin
            wt_m[i]  = 32'd1;
            ifm_m[i] = 32'(i + 1);
        end
        w0 = wa.size();
        r0 = rd_cnt;
        run_job("n3", 8'd3);
        check("n3_nwr", wa.size() - w0, 32'd1);
        check("n3_addr", wa[w0], OFM);
        check("n3_data", wd[w0], 32'd45);
        check("n3_reads", rd_cnt - r0, 32'd18);

        // Same job with ready held low 5 cycles on every request.
        stall = 5;
        w0 = wa.size();
        run_job("stall", 8'd3);
        stall = 0;
        check("stall_nwr", wa.size() - w0, 32'd1);
        check("stall_addr", wa[w0], OFM);
        check("stall_data", wd[w0], 32'd45);
        check("stall_stable", stab_bad, 32'd0);
        check("stall_seen", {31'd0, stab_n > 40}, 32'd1);

        // N=4, centre-tap identity weights, ifm value = index.
        for (int i = 0; i < 9; i++) wt_m[i] = (i == 4) ? 32'd1 : 32'd0;
        for (int i = 0; i < 16; i++) ifm_m[i] = 32'(i);
        w0 = wa.size();
        r0 = rd_cnt;
        run_job("n4", 8'd4);
        check("n4_nwr", wa.size() - w0, 32'd4);
        check("n4_reads", rd_cnt - r0, 32'd45);
        check("n4_a0", wa[w0], OFM);
        check("n4_d0", wd[w0], 32'd5);
        check("n4_a1", wa[w0 + 1], OFM + 32'd4);
        check("n4_d1", wd[w0 + 1], 32'd6);
        check("n4_a2", wa[w0 + 2], OFM + 32'd8);
        check("n4_d2", wd[w0 + 2], 32'd9);
        check("n4_a3", wa[w0 + 3], OFM + 32'd12);
        check("n4_d3", wd[w0 + 3], 32'd10);

        // Reset during WAIT_PX of the N=4 job.
        w0 = wa.size();
        pulse_start(8'd4);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (mem_req_valid_o && mem_req_ready_i && !mem_req_we_o && mem_req_addr_o >= IFM) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstjob_found_px", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rstjob_idle", {31'd0, idle_o}, 32'd1);
        check("rstjob_valid", {31'd0, mem_req_valid_o}, 32'd0);
        check("rstjob_done", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("rstjob_nowr", wa.size() - w0, 32'd0);
        check("rstjob_still_idle", {30'd0, idle_o, done_o}, 32'd2);
        run_job("rerun", 8'd4);
        check("rerun_nwr", wa.size() - w0, 32'd4);
        check("rerun_d0", wd[w0], 32'd5);
        check("rerun_a3", wa[w0 + 3], OFM + 32'd12);
        check("rerun_d3", wd[w0 + 3], 32'd10);

        // Negative result: all -1 weights, ifm 1..9.
        for (int i = 0; i < 9; i++) begin
            wt_m[i]  = 32'hFFFFFFFF;
            ifm_m[i] = 32'(i + 1);
        end
        w0 = wa.size();
        run_job("neg", 8'd3);
        check("neg_nwr", wa.size() - w0, 32'd1);
`ifdef CONV_CTRL_RELU_EN
        check("neg_data", wd[w0], 32'h00000000);
`else
        check("neg_data", wd[w0], 32'hFFFFFFD3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
